// File: rtl/msu_driver_if.sv
// Host-side request/response channel of the msu driver.
// Parameters: WordW (operand/result width), IterBits (iteration count width).
// Signals:
//   req_valid/req_ready/req_sq/req_iters   : request channel (host -> driver)
//   resp_valid/resp_ready/resp_nr/resp_r/resp_err : response channel (driver -> host)
// Modports: master = host/DMA side, slave = driver side.
interface msu_driver_if #(
   parameter int unsigned WordW    = 64,
   parameter int unsigned IterBits = 32
);
   logic                req_valid;
   logic                req_ready;
   logic [WordW-1:0]    req_sq;
   logic [IterBits-1:0] req_iters;
   logic                resp_valid;
   logic                resp_ready;
   logic [WordW-1:0]    resp_nr;
   logic [WordW-1:0]    resp_r;
   logic                resp_err;

   modport master (
      output req_valid, req_sq, req_iters, resp_ready,
      input  req_ready, resp_valid, resp_nr, resp_r, resp_err
   );

   modport slave (
      input  req_valid, req_sq, req_iters, resp_ready,
      output req_ready, resp_valid, resp_nr, resp_r, resp_err
   );
endinterface

// File: rtl/msu_driver.sv
// Host-side sequencer for the modular squaring unit (msu).
// Accepts an operand and iteration count, pulses msu start, waits
// iters*CyclesPerSquare cycles, pulses stop, captures the redundant result
// (or times out) and returns it over the response channel.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   host               : msu_driver_if.slave request/response channel
//   msu_start_o/stop_o : one-cycle control pulses to the msu
//   msu_sq_nr_o        : operand to the msu, held from accept to next accept
//   msu_sq_r_o         : redundant operand half, tied to zero
//   msu_sq_nr_i/sq_r_i : msu result halves
//   msu_valid_i        : msu result valid
// Optional feature macro MSU_DRIVER_ABORT_EN adds abort_i / resp_aborted_o.
module msu_driver #(
   parameter int unsigned IterBits        = 32,
   parameter int unsigned CyclesPerSquare = 2,
   parameter int unsigned DrainTimeout    = 16,
   parameter int unsigned WordW           = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   msu_driver_if.slave      host,
`ifdef MSU_DRIVER_ABORT_EN
   input  logic             abort_i,
   output logic             resp_aborted_o,
`endif
   output logic             msu_start_o,
   output logic             msu_stop_o,
   output logic [WordW-1:0] msu_sq_nr_o,
   output logic [WordW-1:0] msu_sq_r_o,
   input  logic [WordW-1:0] msu_sq_nr_i,
   input  logic [WordW-1:0] msu_sq_r_i,
   input  logic             msu_valid_i
);

   localparam int unsigned CntW = IterBits + 8;
   localparam int unsigned TmoW = (DrainTimeout < 2) ? 1 : $clog2(DrainTimeout);

   typedef enum logic [2:0] {IDLE, START, RUN, STOP, DRAIN, RESP} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d, total;
   logic [TmoW-1:0]     tmo_q, tmo_d;
   logic [IterBits-1:0] iters_q, iters_d;
   logic [WordW-1:0]    sq_d, nr_d, r_d;
   logic                err_d, abrt_q, abrt_d;

   assign msu_sq_r_o = '0;
   assign total      = CntW'(iters_q) * CntW'(CyclesPerSquare);

`ifdef MSU_DRIVER_ABORT_EN
   assign resp_aborted_o = abrt_q;
`endif

   // State, datapath and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         tmo_q           <= '0;
         iters_q         <= '0;
         abrt_q          <= 1'b0;
         msu_sq_nr_o     <= '0;
         msu_start_o     <= 1'b0;
         msu_stop_o      <= 1'b0;
         host.req_ready  <= 1'b1;
         host.resp_valid <= 1'b0;
         host.resp_nr    <= '0;
         host.resp_r     <= '0;
         host.resp_err   <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         tmo_q           <= tmo_d;
         iters_q         <= iters_d;
         abrt_q          <= abrt_d;
         msu_sq_nr_o     <= sq_d;
         msu_start_o     <= (state_d == START);
         msu_stop_o      <= (state_d == STOP);
         host.req_ready  <= (state_d == IDLE);
         host.resp_valid <= (state_d == RESP);
         host.resp_nr    <= nr_d;
         host.resp_r     <= r_d;
         host.resp_err   <= err_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      iters_d = iters_q;
      abrt_d  = abrt_q;
      sq_d    = msu_sq_nr_o;
      nr_d    = host.resp_nr;
      r_d     = host.resp_r;
      err_d   = host.resp_err;
      unique case (state_q)
         IDLE: begin
            if (host.req_valid && host.req_ready) begin
               sq_d    = host.req_sq;
               iters_d = host.req_iters;
               abrt_d  = 1'b0;
               if (host.req_iters == '0) begin
                  // Zero iterations: the operand is already the result
                  state_d = RESP;
                  nr_d    = host.req_sq;
                  r_d     = '0;
                  err_d   = 1'b0;
               end else begin
                  state_d = START;
               end
            end
         end
         START: begin
            // The start cycle counts as the first of the total cycles
            if (total == CntW'(1)) begin
               state_d = STOP;
            end else begin
               cnt_d   = total - CntW'(1);
               state_d = RUN;
            end
`ifdef MSU_DRIVER_ABORT_EN
            if (abort_i) begin
               state_d = STOP;
               abrt_d  = 1'b1;
            end
`endif
         end
         RUN: begin
            if (cnt_q <= CntW'(1)) begin
               state_d = STOP;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
`ifdef MSU_DRIVER_ABORT_EN
            if (abort_i) begin
               state_d = STOP;
               abrt_d  = 1'b1;
            end
`endif
         end
         STOP: begin
            // Timeout is measured from the stop cycle
            tmo_d   = TmoW'(DrainTimeout - 1);
            state_d = DRAIN;
         end
         DRAIN: begin
            if (msu_valid_i) begin
               nr_d    = msu_sq_nr_i;
               r_d     = msu_sq_r_i;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (tmo_q <= TmoW'(1)) begin
               nr_d    = msu_sq_nr_i;
               r_d     = msu_sq_r_i;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               tmo_d = tmo_q - TmoW'(1);
            end
         end
         RESP: begin
            if (host.resp_ready) begin
               state_d = IDLE;
               abrt_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_msu_driver.sv
// Self-checking bench for msu_driver with a mock msu and a reference
// model of repeated modular squaring.
module tb_msu_driver;
   localparam int unsigned WordW = 64;
   localparam int unsigned IterBits = 32;
   localparam int unsigned Cps = 2;
   localparam int unsigned Dto = 16;
   localparam logic [63:0] Mod = 64'd1000003;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic msu_start, msu_stop, mock_valid, abort;
   logic [WordW-1:0] drv_sq_nr, drv_sq_r, mock_nr, mock_r;
   logic aborted;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   bit mute = 1'b0;

   msu_driver_if #(.WordW(WordW), .IterBits(IterBits)) host ();

   msu_driver #(
      .IterBits(IterBits), .CyclesPerSquare(Cps), .DrainTimeout(Dto), .WordW(WordW)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .host(host),
`ifdef MSU_DRIVER_ABORT_EN
      .abort_i(abort),
      .resp_aborted_o(aborted),
`endif
      .msu_start_o(msu_start),
      .msu_stop_o(msu_stop),
      .msu_sq_nr_o(drv_sq_nr),
      .msu_sq_r_o(drv_sq_r),
      .msu_sq_nr_i(mock_nr),
      .msu_sq_r_i(mock_r),
      .msu_valid_i(mock_valid)
   );

`ifndef MSU_DRIVER_ABORT_EN
   assign aborted = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Mock msu: one squaring per Cps cycles while running, valid 3 cycles after stop
   logic [63:0] mx;
   int ph, vcnt;
   bit mrun;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mx <= '0; ph <= 0; mrun <= 1'b0; vcnt <= 0;
      end else begin
         if (msu_start) begin
            mx <= drv_sq_nr; ph <= 0; mrun <= 1'b1; vcnt <= 0;
         end else if (mrun) begin
            if (ph == Cps - 1) begin
               mx <= (mx * mx) % Mod; ph <= 0;
            end else ph <= ph + 1;
         end
         if (msu_stop) begin
            mrun <= 1'b0; vcnt <= 3;
         end else if (vcnt > 0) vcnt <= vcnt - 1;
      end
   end
   assign mock_valid = !mute && (vcnt == 1);
   assign mock_r     = mx / 3;
   assign mock_nr    = mx - mx / 3;

   function automatic logic [63:0] ref_sq(input logic [63:0] x, input int n);
      logic [63:0] v = x;
      for (int i = 0; i < n; i++) v = (v * v) % Mod;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One transaction: drive request, track pulses, check timing and result
   task automatic txn(input logic [63:0] sq, input int iters, input bit mt,
                      input int abort_off, input int hold, input bit accept_it);
      int a, st, sp, rc, nstart, nstop, n;
      logic [63:0] nr0, r0, e0;
      bit seen;
      mute = mt;
      @(negedge clk);
      chk("req_ready_idle", 64'(host.req_ready), 64'd1);
      host.req_valid = 1'b1; host.req_sq = sq; host.req_iters = IterBits'(iters);
      a = cyc; st = -1; sp = -1; rc = -1; nstart = 0; nstop = 0; seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         host.req_valid = 1'b0;
         abort = 1'b0;
         if (msu_start) begin nstart++; st = cyc; chk("sq_at_start", drv_sq_nr, sq); end
         if (msu_stop)  begin nstop++;  sp = cyc; chk("sq_at_stop", drv_sq_nr, sq); end
         if (abort_off >= 0 && st >= 0 && cyc == st + abort_off) abort = 1'b1;
         if (host.resp_valid) begin rc = cyc; seen = 1'b1; break; end
         if (host.req_ready) begin chk("req_ready_busy", 64'(host.req_ready), 64'd0); end
      end
      abort = 1'b0;
      chk("resp_seen", 64'(seen), 64'd1);
      if (!seen) return;
      n = (abort_off >= 0) ? (abort_off + 1) : iters * Cps;
      if (iters == 0) begin
         chk("zero_rc", 64'(rc), 64'(a + 1));
         chk("zero_pulses", 64'(nstart + nstop), 64'd0);
         chk("zero_nr", host.resp_nr, sq);
         chk("zero_r", host.resp_r, 64'd0);
      end else begin
         chk("start_cyc", 64'(st), 64'(a + 1));
         chk("stop_cyc", 64'(sp), 64'(st + n));
         chk("pulse_cnt", 64'(nstart * 16 + nstop), 64'd17);
         chk("resp_cyc", 64'(rc), 64'(sp + (mt ? Dto : 4)));
         if (!mt) chk("resp_sum", host.resp_nr + host.resp_r, ref_sq(sq, n / Cps));
      end
      chk("resp_err", 64'(host.resp_err), 64'(mt));
`ifdef MSU_DRIVER_ABORT_EN
      chk("resp_aborted", 64'(aborted), 64'(abort_off >= 0));
`endif
      chk("msu_sq_r_zero", drv_sq_r, 64'd0);
      nr0 = host.resp_nr; r0 = host.resp_r; e0 = 64'(host.resp_err);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 64'(host.resp_valid), 64'd1);
         chk("hold_data", host.resp_nr ^ host.resp_r ^ 64'(host.resp_err), nr0 ^ r0 ^ e0);
         chk("hold_ready", 64'(host.req_ready), 64'd0);
      end
      if (accept_it) begin
         host.resp_ready = 1'b1;
         @(negedge clk);
         host.resp_ready = 1'b0;
         chk("after_acc_valid", 64'(host.resp_valid), 64'd0);
         chk("after_acc_aborted", 64'(aborted), 64'd0);
      end
      mute = 1'b0;
   endtask

   initial begin
      host.req_valid = 1'b1; host.req_sq = 64'h3; host.req_iters = 1;
      host.resp_ready = 1'b0; abort = 1'b0;
      // Reset with a pending request: nothing may be accepted
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(host.req_ready), 64'd1);
      chk("rst_outs", 64'(host.resp_valid) | 64'(msu_start) | 64'(msu_stop) | 64'(host.resp_err)
          | host.resp_nr | host.resp_r | drv_sq_nr | 64'(aborted), 64'd0);
      host.req_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 64'(host.req_ready) | (64'(msu_start) << 1) | (64'(host.resp_valid) << 2), 64'd1);

      txn(64'h3, 1, 1'b0, -1, 0, 1'b1);
      txn(64'h5, 0, 1'b0, -1, 0, 1'b1);
      // Silent msu, long run, held response
      txn(64'd11, 100, 1'b1, -1, 10, 1'b0);

      // Response accept and new request in the same cycle: request taken one cycle later
      host.resp_ready = 1'b1; host.req_valid = 1'b1; host.req_sq = 64'h9; host.req_iters = 0;
      @(negedge clk);
      host.resp_ready = 1'b0;
      chk("turn_valid", 64'(host.resp_valid), 64'd0);
      chk("turn_ready", 64'(host.req_ready), 64'd1);
      @(negedge clk);
      host.req_valid = 1'b0;
      chk("turn_new_resp", 64'(host.resp_valid), 64'd1);
      chk("turn_new_nr", host.resp_nr, 64'h9);
      host.resp_ready = 1'b1;
      @(negedge clk);
      host.resp_ready = 1'b0;

      // Reset during RUN, then clean restart
      @(negedge clk);
      host.req_valid = 1'b1; host.req_sq = 64'd13; host.req_iters = 50;
      @(negedge clk);
      host.req_valid = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_pulses", 64'(msu_start) | 64'(msu_stop), 64'd0);
      chk("midrst_ready", 64'(host.req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      txn(64'h7, 2, 1'b0, -1, 0, 1'b1);

`ifdef MSU_DRIVER_ABORT_EN
      txn(64'd17, 50, 1'b0, 10, 2, 1'b1);
`endif

      for (int t = 0; t < 8; t++) begin
         txn(64'($urandom_range(1, 1000002)), int'($urandom_range(0, 6)), 1'b0, -1,
             int'($urandom_range(0, 3)), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
